// File: rtl/ctrl_pipe.sv
// ctrl_pipe: decoded-control pipeline registers (D->E, E->M, M->W) for the
// pipelined RISC-V core. Resolves branch/jump in Execute (PCSrcE), turns the
// next Execute slot into a bubble on FlushE or an invalid Decode slot, and
// exports the per-stage control bits used by the hazard unit.
//
// Optional feature: define CTRL_PERF_EN to add the RetireCnt / FlushCnt
// performance counters and their ports. Without it they do not exist.
module ctrl_pipe #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ValidD,
  input  logic             RegWriteD,
  input  logic [1:0]       ResultSrcD,
  input  logic             MemWriteD,
  input  logic             JumpD,
  input  logic             BranchD,
  input  logic             ALUSrcD,
  input  logic [2:0]       ALUControlD,
  input  logic             FlushE,
  input  logic             ZeroE,
  output logic             ALUSrcE,
  output logic [2:0]       ALUControlE,
  output logic             PCSrcE,
  output logic             ResultSrcE0,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic             RegWriteW,
  output logic [1:0]       ResultSrcW
`ifdef CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] RetireCnt,
  output logic [CNT_W-1:0] FlushCnt
`endif
);

  // Counter width sanity check, evaluated at elaboration in every build.
  if (CNT_W < 1) begin : g_cnt_w_check
    $error("ctrl_pipe: CNT_W must be at least 1");
  end

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic [1:0] resultsrc;
    logic       memwrite;
    logic       jump;
    logic       branch;
    logic       alusrc;
    logic [2:0] alucontrol;
  } e_stage_t;

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic [1:0] resultsrc;
    logic       memwrite;
  } m_stage_t;

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic [1:0] resultsrc;
  } w_stage_t;

  e_stage_t e_q, e_next;
  m_stage_t m_q, m_next;
  w_stage_t w_q, w_next;

  // Next Execute contents: a flush or an invalid Decode slot yields a bubble.
  always_comb begin
    e_next = '0;
    if (!FlushE && ValidD) begin
      e_next.valid      = 1'b1;
      e_next.regwrite   = RegWriteD;
      e_next.resultsrc  = ResultSrcD;
      e_next.memwrite   = MemWriteD;
      e_next.jump       = JumpD;
      e_next.branch     = BranchD;
      e_next.alusrc     = ALUSrcD;
      e_next.alucontrol = ALUControlD;
    end
  end

  // Next Memory and Writeback contents: these boundaries always advance.
  always_comb begin
    m_next           = '0;
    m_next.valid     = e_q.valid;
    m_next.regwrite  = e_q.regwrite;
    m_next.resultsrc = e_q.resultsrc;
    m_next.memwrite  = e_q.memwrite;
    w_next           = '0;
    w_next.valid     = m_q.valid;
    w_next.regwrite  = m_q.regwrite;
    w_next.resultsrc = m_q.resultsrc;
  end

  // Stage registers; reset empties all three stages in the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_next;
      m_q <= m_next;
      w_q <= w_next;
    end
  end

  // Stage outputs; side-effecting enables are qualified by the stage valid bit.
  always_comb begin
    ALUSrcE     = e_q.alusrc;
    ALUControlE = e_q.alucontrol;
    PCSrcE      = e_q.valid & ((e_q.branch & ZeroE) | e_q.jump);
    ResultSrcE0 = e_q.resultsrc[0];
    RegWriteM   = m_q.valid & m_q.regwrite;
    MemWriteM   = m_q.valid & m_q.memwrite;
    RegWriteW   = w_q.valid & w_q.regwrite;
    ResultSrcW  = w_q.resultsrc;
  end

`ifdef CTRL_PERF_EN
  // Retire counts instructions entering W; flush counts FlushE cycles. Both wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      RetireCnt <= '0;
      FlushCnt  <= '0;
    end else begin
      if (m_q.valid) begin
        RetireCnt <= RetireCnt + CNT_W'(1);
      end
      if (FlushE) begin
        FlushCnt <= FlushCnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe. The reference model records, per clock
// edge, which bundle entered Execute and whether reset was applied; a stage
// holds the bundle that entered age-in-stages edges ago unless a reset edge
// happened since. Counter checks are compiled in with CTRL_PERF_EN.
module tb_ctrl_pipe;
  localparam int CW   = 4;
  localparam int MAXE = 4096;

  logic       clk = 1'b0;
  logic       reset, ValidD, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
  logic [1:0] ResultSrcD;
  logic [2:0] ALUControlD;
  logic       FlushE, ZeroE;
  logic       ALUSrcE, PCSrcE, ResultSrcE0, RegWriteM, MemWriteM, RegWriteW;
  logic [2:0] ALUControlE;
  logic [1:0] ResultSrcW;
`ifdef CTRL_PERF_EN
  logic [CW-1:0] RetireCnt, FlushCnt;
`endif

  ctrl_pipe #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .ValidD(ValidD), .RegWriteD(RegWriteD),
    .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD), .JumpD(JumpD),
    .BranchD(BranchD), .ALUSrcD(ALUSrcD), .ALUControlD(ALUControlD),
    .FlushE(FlushE), .ZeroE(ZeroE), .ALUSrcE(ALUSrcE),
    .ALUControlE(ALUControlE), .PCSrcE(PCSrcE), .ResultSrcE0(ResultSrcE0),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .RegWriteW(RegWriteW),
    .ResultSrcW(ResultSrcW)
`ifdef CTRL_PERF_EN
    , .RetireCnt(RetireCnt), .FlushCnt(FlushCnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic       rw;
    logic [1:0] rs;
    logic       mw;
    logic       j;
    logic       b;
    logic       as;
    logic [2:0] alu;
  } bnd_t;

  bnd_t ent [MAXE];
  logic rst [MAXE];
  int   ne = 0;
  int   compared = 0;
  int   mismatched = 0;
  int unsigned ret_m = 0;
  int unsigned fl_m  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, ne - 1);
    end
  endtask

  // Bundle visible in stage s (0=E,1=M,2=W) after edge t.
  function automatic bnd_t stage_at(input int s, input int t);
    int idx;
    idx = t - s;
    if (idx < 0) return '0;
    for (int k = idx + 1; k <= t; k++)
      if (rst[k]) return '0;
    return ent[idx];
  endfunction

  // Record what the coming edge does, then advance one cycle.
  task automatic step();
    bnd_t b, w;
    b = '0;
    if (ValidD && !FlushE && !reset)
      b = '{1'b1, RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD, ALUSrcD, ALUControlD};
    ent[ne] = b;
    rst[ne] = reset;
    w = stage_at(2, ne);
    if (reset) begin
      ret_m = 0;
      fl_m  = 0;
    end else begin
      if (w.v)    ret_m = (ret_m + 1) % (1 << CW);
      if (FlushE) fl_m  = (fl_m + 1) % (1 << CW);
    end
    @(posedge clk);
    ne++;
    #2;
  endtask

  task automatic clear_d();
    ValidD = 0; RegWriteD = 0; ResultSrcD = 2'b00; MemWriteD = 0;
    JumpD = 0; BranchD = 0; ALUSrcD = 0; ALUControlD = 3'b000; FlushE = 0;
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin : compare
    bnd_t e, m, w;
    int t;
    if (ne > 0) begin
      t = ne - 1;
      e = stage_at(0, t);
      m = stage_at(1, t);
      w = stage_at(2, t);
      chk("ALUSrcE",     32'(ALUSrcE),     32'(e.as));
      chk("ALUControlE", 32'(ALUControlE), 32'(e.alu));
      chk("PCSrcE",      32'(PCSrcE),      32'(e.v & ((e.b & ZeroE) | e.j)));
      chk("ResultSrcE0", 32'(ResultSrcE0), 32'(e.rs[0]));
      chk("RegWriteM",   32'(RegWriteM),   32'(m.v & m.rw));
      chk("MemWriteM",   32'(MemWriteM),   32'(m.v & m.mw));
      chk("RegWriteW",   32'(RegWriteW),   32'(w.v & w.rw));
      chk("ResultSrcW",  32'(ResultSrcW),  32'(w.rs));
`ifdef CTRL_PERF_EN
      chk("RetireCnt",   32'(RetireCnt),   ret_m);
      chk("FlushCnt",    32'(FlushCnt),    fl_m);
`endif
    end
  end

  initial begin
    // Reset with every D input high.
    reset = 1; ValidD = 1; RegWriteD = 1; ResultSrcD = 2'b11; MemWriteD = 1;
    JumpD = 1; BranchD = 1; ALUSrcD = 1; ALUControlD = 3'b111; FlushE = 1; ZeroE = 1;
    step(); step();
    chk("rst_ALUSrcE", 32'(ALUSrcE), 0);
    chk("rst_ALUControlE", 32'(ALUControlE), 0);
    chk("rst_PCSrcE", 32'(PCSrcE), 0);
    chk("rst_RegWriteW", 32'(RegWriteW), 0);
    chk("rst_ResultSrcW", 32'(ResultSrcW), 0);
`ifdef CTRL_PERF_EN
    chk("rst_RetireCnt", 32'(RetireCnt), 0);
    chk("rst_FlushCnt", 32'(FlushCnt), 0);
`endif
    reset = 0; clear_d();
    step(); step(); step();
    chk("rst_MemWriteM_late", 32'(MemWriteM), 0);

    // lw propagation.
    ValidD = 1; ResultSrcD = 2'b01; RegWriteD = 1; ALUSrcD = 1; ALUControlD = 3'b000;
    step(); clear_d();
    chk("lw_ResultSrcE0", 32'(ResultSrcE0), 1);
    chk("lw_ALUSrcE", 32'(ALUSrcE), 1);
    step();
    chk("lw_RegWriteM", 32'(RegWriteM), 1);
    step();
    chk("lw_RegWriteW", 32'(RegWriteW), 1);
    chk("lw_ResultSrcW", 32'(ResultSrcW), 2'b01);

    // beq taken / not taken.
    ValidD = 1; BranchD = 1; ALUControlD = 3'b001;
    step(); clear_d();
    ZeroE = 1; #1;
    chk("beq_taken", 32'(PCSrcE), 1);
    ZeroE = 0; #1;
    chk("beq_not_taken", 32'(PCSrcE), 0);
    step();
    chk("beq_RegWriteM", 32'(RegWriteM), 0);
    chk("beq_MemWriteM", 32'(MemWriteM), 0);
    step();

    // Flush collision: jal in E, FlushE with a valid sw in D.
    ValidD = 1; JumpD = 1; RegWriteD = 1; ResultSrcD = 2'b10;
    step(); clear_d();
    ValidD = 1; MemWriteD = 1; ALUSrcD = 1; FlushE = 1; ZeroE = 0; #1;
    chk("jal_PCSrcE", 32'(PCSrcE), 1);
    step(); clear_d();
    chk("flush_bubble_ALUSrcE", 32'(ALUSrcE), 0);
    chk("flush_bubble_PCSrcE", 32'(PCSrcE), 0);
    step();
    chk("flush_MemWriteM", 32'(MemWriteM), 0);

    // Invalid D with enables set.
    ValidD = 0; MemWriteD = 1; RegWriteD = 1;
    step(); clear_d();
    step();
    chk("invd_MemWriteM", 32'(MemWriteM), 0);
    step();
    chk("invd_RegWriteW", 32'(RegWriteW), 0);

`ifdef CTRL_PERF_EN
    // Counter wrap: 20 retirements mod 16 = 4, three flush cycles.
    reset = 1; step(); reset = 0;
    for (int i = 0; i < 20; i++) begin
      ValidD = 1; RegWriteD = 1; ResultSrcD = 2'($urandom_range(0, 2));
      step();
    end
    clear_d();
    FlushE = 1;
    for (int i = 0; i < 3; i++) step();
    FlushE = 0;
    for (int i = 0; i < 3; i++) step();
    chk("cnt_RetireCnt_wrap", 32'(RetireCnt), 4);
    chk("cnt_FlushCnt", 32'(FlushCnt), 3);
`endif

    // Randomized traffic including mid-stream resets and flush collisions.
    for (int i = 0; i < 400; i++) begin
      reset       = ($urandom_range(0, 39) == 0);
      ValidD      = ($urandom_range(0, 3) != 0);
      FlushE      = ($urandom_range(0, 4) == 0);
      RegWriteD   = 1'($urandom);
      ResultSrcD  = 2'($urandom_range(0, 2));
      MemWriteD   = 1'($urandom);
      JumpD       = 1'($urandom);
      BranchD     = 1'($urandom);
      ALUSrcD     = 1'($urandom);
      ALUControlD = 3'($urandom);
      ZeroE       = 1'($urandom);
      step();
    end
    clear_d(); reset = 0;
    step(); step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Carries the decoded control bundle from the Decode stage through the Execute, Memory and Writeback pipeline registers of the pipelined RISC-V core. It is the consuming end of the main/ALU decoder outputs. It resolves branches and jumps in Execute, producing `PCSrcE`, and inserts bubbles on `FlushE`. It also exports the per-stage control bits that the hazard unit needs for forwarding and load-use detection.

## Interface
- `CNT_W`, 32: width of the optional performance counters.

- `clk`  in  1  system clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `ValidD`  in  1  instruction in Decode is real (0 after FlushD or at startup)
- `RegWriteD`  in  1  decoder: register write enable
- `ResultSrcD`  in  2  decoder: 00 ALU, 01 memory, 10 PC+4
- `MemWriteD`  in  1  decoder: store
- `JumpD`  in  1  decoder: jal
- `BranchD`  in  1  decoder: beq
- `ALUSrcD`  in  1  decoder: ALU B operand is immediate
- `ALUControlD`  in  3  ALU decoder output
- `FlushE`  in  1  from hazard unit: turn next Execute contents into a bubble
- `ZeroE`  in  1  ALU zero flag, Execute stage, combinational
- `ALUSrcE`  out  1  to Execute datapath
- `ALUControlE`  out  3  to ALU
- `PCSrcE`  out  1  `(BranchE & ZeroE) | JumpE`, combinational
- `ResultSrcE0`  out  1  `ResultSrcE[0]`, load-in-Execute indication for load-use stall
- `RegWriteM`  out  1  to forwarding logic
- `MemWriteM`  out  1  data memory write enable
- `RegWriteW`  out  1  register file write enable and forwarding
- `ResultSrcW`  out  2  Writeback result mux select
- `RetireCnt`  out  CNT_W  valid instructions reaching Writeback (only when `CTRL_PERF_EN` is defined)
- `FlushCnt`  out  CNT_W  cycles with `FlushE` asserted (only when `CTRL_PERF_EN` is defined)

## Operation
- There are three register stages: D→E, E→M and M→W. Each stage holds a valid bit plus the control fields still needed downstream.
  - E holds: Valid, RegWrite, ResultSrc, MemWrite, Jump, Branch, ALUSrc, ALUControl.
  - M holds: Valid, RegWrite, ResultSrc, MemWrite.
  - W holds: Valid, RegWrite, ResultSrc.
- Bubble: every field is 0. A bubble writes no register, performs no store and takes no branch.
- D→E loading:
  - If `reset` or `FlushE`, E loads a bubble.
  - Otherwise, if `ValidD`=0, E also loads a bubble.
  - Otherwise E loads the D fields.
- E→M and M→W always advance. There is no stall at these boundaries.
- Enable gating: all enables are ANDed with the stage valid bit.
  - This applies to RegWrite, MemWrite, Branch and Jump.
  - An invalid stage therefore never produces a side effect, even if the upstream fields are nonzero.
- `PCSrcE` is evaluated from the current E contents and `ZeroE`.
  - `FlushE` in the same cycle affects only the next E contents.
  - It never masks the current `PCSrcE`.
- Branch kill: clearing the wrong-path instruction is the hazard unit's job. It drives `FlushE` and clears `ValidD` via FlushD. This block only obeys those inputs.

## Timing
- Reset:
  - All stage registers clear on the first rising edge with `reset`=1.
  - Outputs after that edge: `ALUSrcE`=0, `ALUControlE`=000, `PCSrcE`=0 (for any `ZeroE`), `ResultSrcE0`=0, `RegWriteM`=0, `MemWriteM`=0, `RegWriteW`=0, `ResultSrcW`=00, counters 0.
- Reset asserted mid-stream flushes all three stages in the same edge. In-flight stores and register writes are dropped.
- Latency:
  - A D-stage bundle appears at the E outputs 1 cycle later, at M 2 cycles later and at W 3 cycles later.
  - `PCSrcE` is combinational in E, with zero added latency from `ZeroE`.
- Simultaneous `FlushE` and `ValidD`=1: the flush wins and E becomes a bubble.

## Configuration
- `CTRL_PERF_EN` defined:
  - `RetireCnt` increments on each edge where W is about to load a valid instruction (`ValidM`=1).
  - `FlushCnt` increments on each edge with `FlushE`=1 and `reset`=0.
  - Both counters are `CNT_W` bits, wrap from all-ones to 0, and clear on reset.
- `CTRL_PERF_EN` undefined: the counter registers and the `RetireCnt`/`FlushCnt` ports do not exist. All other behaviour is identical.

## Test plan
- Reset: hold `reset`=1 for 2 cycles with all D inputs at 1 → all outputs 0, including `MemWriteM`=0 three cycles later; with `CTRL_PERF_EN`, counters read 0.
- lw propagation: apply ResultSrcD=01, RegWriteD=1, ALUSrcD=1, ALUControlD=000, ValidD=1 for one cycle →
  - cycle+1: `ResultSrcE0`=1, `ALUSrcE`=1.
  - cycle+2: `RegWriteM`=1.
  - cycle+3: `RegWriteW`=1, `ResultSrcW`=01.
- beq taken/not-taken: BranchD=1 enters E → `PCSrcE`=1 with ZeroE=1 and `PCSrcE`=0 with ZeroE=0; RegWriteM and MemWriteM stay 0 downstream.
- Flush collision: jal in E (JumpD=1 loaded previously) with FlushE=1 and a valid sw in D →
  - `PCSrcE`=1 this cycle.
  - Next cycle E is a bubble, and 2 cycles later `MemWriteM`=0.
- Invalid D: ValidD=0 with MemWriteD=1, RegWriteD=1 → `MemWriteM`=0 and `RegWriteW`=0 at +2/+3.
- Counters (`CTRL_PERF_EN`, CNT_W=4): 20 consecutive valid instructions then 3 FlushE cycles → `RetireCnt` wraps to 4 after all retire, `FlushCnt`=3.
